// File: rtl/mem_axi_bridge.sv
// Bridges a simple CPU valid/ready memory port onto AXI-lite style read, write and
// write-response channels, one outstanding access at a time, with a per-state timeout.
module mem_axi_bridge #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_err,

    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,

    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,

    input  logic                    b_valid,
    input  logic [1:0]              b_response,
    output logic                    b_ready,

    output logic [2:0]              o_dbg_state
);

    // Handshake rule on every AXI channel: a transfer happens on the rising edge where
    // both valid and ready are high; valids never wait on readies and are all registered.

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_RD_ADDR      = 3'd1,
        S_RD_DATA      = 3'd2,
        S_WR_ADDR_DATA = 3'd3,
        S_WR_RESP      = 3'd4,
        S_DONE         = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;

    logic                    r_mem_ready, w_mem_ready_nxt;
    logic                    r_mem_err,   w_mem_err_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_rdata, w_mem_rdata_nxt;
    logic [ADDR_WIDTH-1:0]   r_araddr,    w_araddr_nxt;
    logic                    r_arvalid,   w_arvalid_nxt;
    logic                    r_rready,    w_rready_nxt;
    logic [ADDR_WIDTH-1:0]   r_awaddr,    w_awaddr_nxt;
    logic                    r_awvalid,   w_awvalid_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata,     w_wdata_nxt;
    logic [STRB_W-1:0]       r_wstrb,     w_wstrb_nxt;
    logic                    r_wvalid,    w_wvalid_nxt;
    logic                    r_bready,    w_bready_nxt;
    logic                    r_aw_done,   w_aw_done_nxt;
    logic                    r_w_done,    w_w_done_nxt;

    logic                    w_ar_hs;
    logic                    w_r_hs;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_b_hs;
    logic                    w_aw_done;
    logic                    w_w_done;
    logic                    w_timeout;
    logic                    w_is_read;
    logic [ADDR_WIDTH-1:0]   w_word_addr;
    logic                    w_unused_addr_bits;

    assign w_ar_hs     = r_arvalid & axi_arready;
    assign w_r_hs      = r_rready & axi_rvalid;
    assign w_aw_hs     = r_awvalid & axi_awready;
    assign w_w_hs      = r_wvalid & axi_wready;
    assign w_b_hs      = r_bready & b_valid;
    assign w_aw_done   = r_aw_done | w_aw_hs;
    assign w_w_done    = r_w_done | w_w_hs;
    assign w_is_read   = (mem_wstrb == '0);
    assign w_word_addr = mem_addr[ADDR_WIDTH+1:2];

    // The edge that would take the counter to TIMEOUT is the one that gives up.
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
            r_mem_rdata <= '0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_ready <= w_mem_ready_nxt;
            r_mem_err   <= w_mem_err_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_araddr    <= w_araddr_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_aw_done   <= w_aw_done_nxt;
            r_w_done    <= w_w_done_nxt;
        end
    end

    // Next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_state_nxt = w_is_read ? S_RD_ADDR : S_WR_ADDR_DATA;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs)        w_state_nxt = S_RD_DATA;
                else if (w_timeout) w_state_nxt = S_DONE;
            end
            S_RD_DATA: begin
                if (w_r_hs || w_timeout) w_state_nxt = S_DONE;
            end
            S_WR_ADDR_DATA: begin
                if (w_aw_done && w_w_done) w_state_nxt = S_WR_RESP;
                else if (w_timeout)        w_state_nxt = S_DONE;
            end
            S_WR_RESP: begin
                if (w_b_hs || w_timeout) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_mem_err_nxt   = r_mem_err;
        w_mem_rdata_nxt = r_mem_rdata;
        w_araddr_nxt    = r_araddr;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awaddr_nxt    = r_awaddr;
        w_awvalid_nxt   = r_awvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_aw_done_nxt   = r_aw_done;
        w_w_done_nxt    = r_w_done;
        w_mem_ready_nxt = (w_state_nxt == S_DONE);

        case (r_state)
            S_IDLE: begin
                if (mem_valid && w_is_read) begin
                    w_araddr_nxt  = w_word_addr;
                    w_arvalid_nxt = 1'b1;
                end else if (mem_valid) begin
                    w_awaddr_nxt  = w_word_addr;
                    w_wdata_nxt   = mem_wdata;
                    w_wstrb_nxt   = mem_wstrb;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_arvalid_nxt   = 1'b0;
                    w_mem_err_nxt   = 1'b1;
                    w_mem_rdata_nxt = '0;
                end
            end
            S_RD_DATA: begin
                if (w_r_hs) begin
                    w_rready_nxt    = 1'b0;
                    w_mem_rdata_nxt = axi_rdata;
                end else if (w_timeout) begin
                    w_rready_nxt    = 1'b0;
                    w_mem_err_nxt   = 1'b1;
                    w_mem_rdata_nxt = '0;
                end
            end
            S_WR_ADDR_DATA: begin
                // Each channel retires on its own handshake; the later one opens the response.
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_awvalid_nxt   = 1'b0;
                    w_wvalid_nxt    = 1'b0;
                    w_mem_err_nxt   = 1'b1;
                    w_mem_rdata_nxt = '0;
                end
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt  = 1'b0;
                    w_mem_err_nxt = (b_response != 2'b00);
                end else if (w_timeout) begin
                    w_bready_nxt    = 1'b0;
                    w_mem_err_nxt   = 1'b1;
                    w_mem_rdata_nxt = '0;
                end
            end
            S_DONE: begin
                w_mem_err_nxt = 1'b0;
            end
            default: begin
                w_mem_err_nxt = 1'b0;
            end
        endcase
    end

    // Wait counter: zero on every state change, counts only while waiting on the slave.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state != S_IDLE && r_state != S_DONE && r_cnt != CNT_W'(TIMEOUT)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign mem_ready   = r_mem_ready;
    assign mem_err     = r_mem_err;
    assign mem_rdata   = r_mem_rdata;
    assign axi_araddr  = r_araddr;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = r_rready;
    assign axi_awaddr  = r_awaddr;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_wvalid  = r_wvalid;
    assign b_ready     = r_bready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Table-driven bench for mem_axi_bridge: a delay-configurable BRAM slave, a negedge
// monitor, a vector table of CPU accesses and hand sequences for timeout/reset corners.
module tb_mem_axi_bridge;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          mem_err;
    logic [AW-1:0] axi_araddr;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [AW-1:0] axi_awaddr;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [3:0]    axi_wstrb;
    logic          axi_wvalid;
    logic          axi_wready;
    logic          b_valid;
    logic [1:0]    b_response;
    logic          b_ready;
    logic [2:0]    o_dbg_state;

    mem_axi_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_err(mem_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .b_valid(b_valid), .b_response(b_response), .b_ready(b_ready),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- slave model ----------------
    logic [DW-1:0] bram [0:(1<<AW)-1];
    int            cfg_ar_dly, cfg_aw_dly, cfg_w_dly;
    logic [1:0]    cfg_bresp;
    logic          cfg_r_hold;
    logic          inj_stray;
    int            ar_wait, aw_wait, w_wait;
    logic          rd_pending, aw_got, w_got;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;

    initial begin
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        bram[0]     = 32'h1357_9BDF;
        bram[2]     = 32'h5566_7788;
        bram[3]     = 32'hAABB_CCDD;
        bram[4]     = 32'hDEAD_BEEF;
        bram[10'h3FF] = 32'h0BAD_F00D;
        cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bresp = 2'b00;
        cfg_r_hold = 1'b0; inj_stray = 1'b0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        rd_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; b_valid = 1'b0; b_response = 2'b00;
        forever begin
            @(negedge clk);
            axi_rvalid = inj_stray;
            b_valid    = inj_stray;
            b_response = inj_stray ? 2'b11 : 2'b00;
            if (rd_pending && axi_rready && !cfg_r_hold) begin
                axi_rvalid = 1'b1;
                axi_rdata  = bram[rd_addr];
                rd_pending = 1'b0;
            end
            if (aw_got && w_got && b_ready) begin
                if (cfg_bresp == 2'b00) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) bram[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                end
                b_valid    = 1'b1;
                b_response = cfg_bresp;
                aw_got     = 1'b0;
                w_got      = 1'b0;
            end
            axi_arready = 1'b0;
            if (axi_arvalid) begin
                if (ar_wait >= cfg_ar_dly) begin
                    axi_arready = 1'b1; rd_addr = axi_araddr; rd_pending = 1'b1; ar_wait = 0;
                end else ar_wait++;
            end else ar_wait = 0;
            axi_awready = 1'b0;
            if (axi_awvalid) begin
                if (aw_wait >= cfg_aw_dly) begin
                    axi_awready = 1'b1; wr_addr = axi_awaddr; aw_got = 1'b1; aw_wait = 0;
                end else aw_wait++;
            end else aw_wait = 0;
            axi_wready = 1'b0;
            if (axi_wvalid) begin
                if (w_wait >= cfg_w_dly) begin
                    axi_wready = 1'b1; wr_data = axi_wdata; wr_strb = axi_wstrb; w_got = 1'b1; w_wait = 0;
                end else w_wait++;
            end else w_wait = 0;
        end
    end

    // ---------------- monitor ----------------
    int            cnt_ready, cnt_arv, cnt_awv, cnt_wv, cnt_busy;
    logic [AW-1:0] mon_ar, mon_aw;
    logic [DW-1:0] mon_wdata;
    logic [3:0]    mon_wstrb;

    initial begin
        cnt_ready = 0; cnt_arv = 0; cnt_awv = 0; cnt_wv = 0; cnt_busy = 0;
        mon_ar = '0; mon_aw = '0; mon_wdata = '0; mon_wstrb = '0;
        forever begin
            @(negedge clk);
            if (axi_arvalid) begin mon_ar = axi_araddr; cnt_arv++; end
            if (axi_awvalid) begin mon_aw = axi_awaddr; cnt_awv++; end
            if (axi_wvalid) begin mon_wdata = axi_wdata; mon_wstrb = axi_wstrb; cnt_wv++; end
            if (mem_ready) cnt_ready++;
            if (o_dbg_state != 3'd0) cnt_busy++;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks, n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        int            ar_dly;
        int            aw_dly;
        int            w_dly;
        logic [1:0]    bresp;
        logic [AW-1:0] exp_ax;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int ar, input int aw, input int w,
                                input logic [1:0] bresp, input logic [AW-1:0] ax,
                                input logic [31:0] rdata, input logic err, input int lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = strb;
        v.ar_dly = ar; v.aw_dly = aw; v.w_dly = w; v.bresp = bresp;
        v.exp_ax = ax; v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Latency counts the cycles mem_valid is high, including the mem_ready cycle.
    task automatic do_access(input vec_t v, output logic [31:0] rdata, output logic err,
                             output int lat, output int pulses);
        int  c0;
        logic seen;
        cfg_ar_dly = v.ar_dly; cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_bresp = v.bresp;
        @(negedge clk); #1;
        c0 = cnt_ready;
        seen = 1'b0; rdata = '0; err = 1'b0; lat = 0;
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wr ? v.wstrb : 4'h0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk); #1;
            if (i == 1) begin
                mem_addr  = 32'hFFFF_FFFC;
                mem_wdata = ~v.wdata;
                mem_wstrb = v.wr ? 4'h0 : 4'hF;
            end
            if (mem_ready) begin
                rdata = mem_rdata; err = mem_err; lat = i + 1; seen = 1'b1;
                mem_valid = 1'b0;
                break;
            end
        end
        mem_valid = 1'b0;
        if (!seen) check("access_timeout_no_ready", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        #1;
        pulses = cnt_ready - c0;
    endtask

    // ---------------- test ----------------
    vec_t        vecs[12];
    logic [31:0] g_rdata;
    logic        g_err;
    int          g_lat, g_pulses;
    int          s_awv, s_wv, s_arv, s_rdy, s_busy;
    logic        reached;

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;

        //            wr    addr           wdata          strb     ar aw w  bresp  ax       rdata          err  lat
        vecs[0]  = mk(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h004, 32'hDEAD_BEEF, 1'b0, 4);
        vecs[1]  = mk(1'b1, 32'h0000_000C, 32'h1122_3344, 4'b0101, 0, 0, 0, 2'b00, 10'h003, 32'h0,         1'b0, 4);
        vecs[2]  = mk(1'b0, 32'h0000_000C, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h003, 32'hAA22_CC44, 1'b0, 4);
        vecs[3]  = mk(1'b0, 32'hABCD_1FFC, 32'h0,         4'b0000, 2, 0, 0, 2'b00, 10'h3FF, 32'h0BAD_F00D, 1'b0, 6);
        vecs[4]  = mk(1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'b1111, 0, 1, 3, 2'b00, 10'h3FF, 32'h0,         1'b0, 7);
        vecs[5]  = mk(1'b0, 32'h0000_1FFC, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h3FF, 32'hCAFE_F00D, 1'b0, 4);
        vecs[6]  = mk(1'b1, 32'h0000_0008, 32'h0000_AB00, 4'b0010, 0, 0, 0, 2'b10, 10'h002, 32'h0,         1'b1, 4);
        vecs[7]  = mk(1'b0, 32'h0000_0008, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h002, 32'h5566_7788, 1'b0, 4);
        vecs[8]  = mk(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b1100, 0, 0, 0, 2'b00, 10'h002, 32'h0,         1'b0, 4);
        vecs[9]  = mk(1'b0, 32'h0000_0008, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h002, 32'h1234_7788, 1'b0, 4);
        vecs[10] = mk(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'b1111, 0, 0, 2, 2'b11, 10'h001, 32'h0,         1'b1, 6);
        vecs[11] = mk(1'b0, 32'h0000_0003, 32'h0,         4'b0000, 0, 0, 0, 2'b00, 10'h000, 32'h1357_9BDF, 1'b0, 4);

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_outputs",
              {32'd0, mem_ready, mem_err, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, b_ready, o_dbg_state},
              64'd0);
        check("reset_data", {mem_rdata, 2'b00, axi_araddr, 2'b00, axi_awaddr}, 64'd0);
        check("reset_wdata", {axi_wdata, 28'd0, axi_wstrb}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i], g_rdata, g_err, g_lat, g_pulses);
            check($sformatf("v%0d_err", i), g_err, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), g_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_ready_pulses", i), g_pulses, 1);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_awaddr", i), mon_aw, vecs[i].exp_ax);
                check($sformatf("v%0d_wdata", i), mon_wdata, vecs[i].wdata);
                check($sformatf("v%0d_wstrb", i), mon_wstrb, vecs[i].wstrb);
            end else begin
                check($sformatf("v%0d_araddr", i), mon_ar, vecs[i].exp_ax);
                check($sformatf("v%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
            end
        end

        // awready held off while wready is immediate
        s_awv = cnt_awv; s_wv = cnt_wv;
        do_access(mk(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 4, 0, 2'b00, 10'h004, 32'h0, 1'b0, 8),
                  g_rdata, g_err, g_lat, g_pulses);
        check("awdly_awvalid_cycles", cnt_awv - s_awv, 5);
        check("awdly_wvalid_cycles", cnt_wv - s_wv, 1);
        check("awdly_latency", g_lat, 8);
        check("awdly_pulses", g_pulses, 1);
        check("awdly_err", g_err, 1'b0);
        do_access(mk(1'b0, 32'h10, 32'h0, 4'b0000, 0, 0, 0, 2'b00, 10'h004, 32'h0, 1'b0, 4),
                  g_rdata, g_err, g_lat, g_pulses);
        check("awdly_readback", g_rdata, 32'hDEAD_BEAA);

        // slave never accepts the read address
        s_arv = cnt_arv;
        do_access(mk(1'b0, 32'h10, 32'h0, 4'b0000, 99, 0, 0, 2'b00, 10'h004, 32'h0, 1'b1, 17),
                  g_rdata, g_err, g_lat, g_pulses);
        check("tmo_err", g_err, 1'b1);
        check("tmo_rdata", g_rdata, 32'h0);
        check("tmo_latency", g_lat, 17);
        check("tmo_pulses", g_pulses, 1);
        check("tmo_arvalid_cycles", cnt_arv - s_arv, 15);
        check("tmo_arvalid_after", axi_arvalid, 1'b0);

        // stray responses while idle
        s_rdy = cnt_ready; s_busy = cnt_busy;
        inj_stray = 1'b1;
        repeat (4) @(negedge clk);
        #1 inj_stray = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stray_busy_cycles", cnt_busy - s_busy, 0);
        check("stray_pulses", cnt_ready - s_rdy, 0);
        check("stray_err", mem_err, 1'b0);

        // reset while waiting for read data
        cfg_ar_dly = 0; cfg_r_hold = 1'b1;
        s_rdy = cnt_ready;
        mem_valid = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'h0;
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (o_dbg_state == 3'd2) begin reached = 1'b1; break; end
        end
        check("rst_reached_rd_data", reached, 1'b1);
        rst = 1'b1; mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        cfg_r_hold = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_pulse", cnt_ready - s_rdy, 0);
        check("rst_state_idle", o_dbg_state, 3'd0);
        check("rst_rready_low", axi_rready, 1'b0);
        check("rst_rdata_zero", mem_rdata, 32'h0);
        do_access(mk(1'b0, 32'h10, 32'h0, 4'b0000, 0, 0, 0, 2'b00, 10'h004, 32'h0, 1'b0, 4),
                  g_rdata, g_err, g_lat, g_pulses);
        check("post_rst_rdata", g_rdata, 32'hDEAD_BEAA);
        check("post_rst_err", g_err, 1'b0);
        check("post_rst_latency", g_lat, 4);
        check("post_rst_pulses", g_pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
